// File: rtl/multicycle_control_pkg.sv
// Shared core definitions for the multicycle controller: opcode encodings,
// ALU control codes, datapath mux selects and the registered control bundle.
package multicycle_control_pkg;

   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;

   localparam logic [1:0] ALU_OP_ADD    = 2'b00;
   localparam logic [1:0] ALU_OP_SUB    = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;
   localparam logic [1:0] ALU_OP_BRANCH = 2'b11;

   localparam logic [1:0] SRC_A_PC   = 2'b00;
   localparam logic [1:0] SRC_A_RS1  = 2'b01;
   localparam logic [1:0] SRC_A_ZERO = 2'b10;

   localparam logic [1:0] SRC_B_RS2  = 2'b00;
   localparam logic [1:0] SRC_B_IMM  = 2'b01;
   localparam logic [1:0] SRC_B_FOUR = 2'b10;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;

   // ALU funct3 and branch-compare constants used by the datapath ALU decoder.
   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_BEQ     = 3'b000;
   localparam logic [2:0] F3_BNE     = 3'b001;
   localparam logic [2:0] F3_BLT     = 3'b100;
   localparam logic [2:0] F3_BGE     = 3'b101;

   typedef struct packed {
      logic [1:0] alu_op;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic       pc_write;
      logic       pc_write_cond;
      logic       pc_source;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic [1:0] wb_sel;
      logic       illegal_inst;
   } ctrl_t;

endpackage

// File: rtl/multicycle_control_wait_counter.sv
// Memory wait timer: counts consecutive stalled cycles and flags the cycle
// in which the stall reaches LIMIT.
module multicycle_control_wait_counter #(
   parameter int unsigned LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic count_en_i,
   output logic at_limit_o
);

   localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

   logic [CNT_W-1:0] count_q, count_d;

   // Any non-stalled cycle clears the count, so each wait state starts from zero.
   assign at_limit_o = count_en_i && (count_q == CNT_W'(LIMIT - 1));
   assign count_d    = !count_en_i ? '0 :
                       at_limit_o  ? count_q : count_q + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V style control FSM: sequences fetch, decode, execute,
// memory and write-back, and traps on illegal opcodes or memory timeouts.
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int unsigned MEM_WAIT_LIMIT = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic       mem_ready,
   output logic [1:0] alu_op,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic       ir_write,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       pc_source,
   output logic       mem_read,
   output logic       mem_write,
   output logic       reg_write,
   output logic [1:0] wb_sel,
   output logic       illegal_inst
);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXEC_OP, S_EXEC_BR, S_EXEC_JAL, S_EXEC_JALR, S_EXEC_UI,
      S_MEM_ADDR, S_MEM_RD, S_MEM_WR, S_WB_ALU, S_WB_MEM, S_TRAP
   } state_e;

   state_e state_q, state_d;
   ctrl_t  ctrl_q;
   logic   waiting, mem_timeout, fetch_done;

   function automatic state_e dispatch(input logic [6:0] opc);
      case (opc)
         OPC_OP, OPC_OP_IMM, OPC_OP_32, OPC_OP_IMM_32: return S_EXEC_OP;
         OPC_LOAD, OPC_STORE:                          return S_MEM_ADDR;
         OPC_BRANCH:                                   return S_EXEC_BR;
         OPC_JAL:                                      return S_EXEC_JAL;
         OPC_JALR:                                     return S_EXEC_JALR;
         OPC_LUI, OPC_AUIPC:                           return S_EXEC_UI;
         default:                                      return S_TRAP;
      endcase
   endfunction

   function automatic ctrl_t ctrl_for(input state_e s, input logic [6:0] opc);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH:     begin c.mem_read = 1'b1; c.alu_src_a = SRC_A_PC; c.alu_src_b = SRC_B_FOUR; end
         S_DECODE:    begin c.alu_src_a = SRC_A_PC; c.alu_src_b = SRC_B_IMM; end
         S_EXEC_OP:   begin
            c.alu_op    = ALU_OP_FUNCT;
            c.alu_src_a = SRC_A_RS1;
            c.alu_src_b = (opc == OPC_OP || opc == OPC_OP_32) ? SRC_B_RS2 : SRC_B_IMM;
         end
         S_EXEC_BR:   begin
            c.alu_op = ALU_OP_BRANCH; c.alu_src_a = SRC_A_RS1; c.alu_src_b = SRC_B_RS2;
            c.pc_write_cond = 1'b1; c.pc_source = 1'b1;
         end
         S_EXEC_JAL:  begin c.pc_write = 1'b1; c.pc_source = 1'b1; c.reg_write = 1'b1; c.wb_sel = WB_PC4; end
         S_EXEC_JALR: begin
            c.alu_op = ALU_OP_ADD; c.alu_src_a = SRC_A_RS1; c.alu_src_b = SRC_B_IMM;
            c.pc_write = 1'b1; c.reg_write = 1'b1; c.wb_sel = WB_PC4;
         end
         S_EXEC_UI:   begin
            c.alu_src_a = (opc == OPC_LUI) ? SRC_A_ZERO : SRC_A_PC;
            c.alu_src_b = SRC_B_IMM;
         end
         S_MEM_ADDR:  begin c.alu_src_a = SRC_A_RS1; c.alu_src_b = SRC_B_IMM; end
         S_MEM_RD:    c.mem_read  = 1'b1;
         S_MEM_WR:    c.mem_write = 1'b1;
         S_WB_ALU:    begin c.reg_write = 1'b1; c.wb_sel = WB_ALU; end
         S_WB_MEM:    begin c.reg_write = 1'b1; c.wb_sel = WB_MEM; end
         S_TRAP:      c.illegal_inst = 1'b1;
         default:     ;
      endcase
      return c;
   endfunction

   assign waiting = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

   multicycle_control_wait_counter #(
      .LIMIT(MEM_WAIT_LIMIT)
   ) u_wait_counter (
      .clk       (clk),
      .rst       (rst),
      .count_en_i(waiting && !mem_ready),
      .at_limit_o(mem_timeout)
   );

   always_comb begin
      // NOTE: default assignment first so no path through the case infers a latch.
      state_d = state_q;
      case (state_q)
         S_FETCH:                  if (mem_ready) state_d = S_DECODE; else if (mem_timeout) state_d = S_TRAP;
         S_DECODE:                 state_d = dispatch(opcode);
         S_EXEC_OP, S_EXEC_UI:     state_d = S_WB_ALU;
         S_MEM_ADDR:               state_d = (opcode == OPC_STORE) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:                 if (mem_ready) state_d = S_WB_MEM; else if (mem_timeout) state_d = S_TRAP;
         S_MEM_WR:                 if (mem_ready) state_d = S_FETCH;  else if (mem_timeout) state_d = S_TRAP;
         S_EXEC_BR, S_EXEC_JAL, S_EXEC_JALR,
         S_WB_ALU, S_WB_MEM:       state_d = S_FETCH;
         S_TRAP:                   state_d = S_TRAP;
         default:                  state_d = S_TRAP;
      endcase
   end

   // NOTE: outputs are decoded from the next state and registered, so they
   // change on the same edge as state_q and never glitch.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         ctrl_q  <= ctrl_for(S_FETCH, opcode);
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_for(state_d, opcode);
      end
   end

   // The fetch handshake completes in the same cycle as mem_ready, so the IR
   // load and PC increment follow mem_ready directly; rst blocks every write.
   assign fetch_done    = (state_q == S_FETCH) && mem_ready && !rst;
   assign ir_write      = fetch_done;
   assign pc_write      = (ctrl_q.pc_write || fetch_done) && !rst;
   assign pc_write_cond = ctrl_q.pc_write_cond && !rst;
   assign mem_write     = ctrl_q.mem_write && !rst;
   assign reg_write     = ctrl_q.reg_write && !rst;
   assign pc_source     = ctrl_q.pc_source;
   assign mem_read      = ctrl_q.mem_read;
   assign alu_op        = ctrl_q.alu_op;
   assign alu_src_a     = ctrl_q.alu_src_a;
   assign alu_src_b     = ctrl_q.alu_src_b;
   assign wb_sel        = ctrl_q.wb_sel;
   assign illegal_inst  = ctrl_q.illegal_inst;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven bench for multicycle_control (MEM_WAIT_LIMIT = 4).
module tb_multicycle_control;

   typedef struct packed {
      logic [1:0] alu_op;
      logic [1:0] src_a;
      logic [1:0] src_b;
      logic       ir_w;
      logic       pc_w;
      logic       pc_c;
      logic       pc_s;
      logic       m_r;
      logic       m_w;
      logic       r_w;
      logic [1:0] wb;
      logic       ill;
   } out_t;

   typedef struct {
      logic       rst;
      logic [6:0] op;
      logic       rdy;
      out_t       exp;
      string      name;
   } vec_t;

   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_32     = 7'b0111011;
   localparam logic [6:0] OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BEQ    = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_BAD    = 7'b0000000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] opcode = 7'b0;
   logic       mem_ready = 1'b0;
   logic [1:0] alu_op, alu_src_a, alu_src_b, wb_sel;
   logic       ir_write, pc_write, pc_write_cond, pc_source;
   logic       mem_read, mem_write, reg_write, illegal_inst;

   int checks   = 0;
   int failures = 0;

   vec_t vecs[$];

   out_t E_ZERO, E_FETCH, E_FETCH_RDY, E_DECODE, E_OP_R, E_OP_I, E_BR, E_JAL, E_JALR;
   out_t E_LUI, E_AUIPC, E_MADDR, E_MRD, E_MWR, E_WB_ALU, E_WB_MEM, E_TRAP;

   always #5 clk = ~clk;

   multicycle_control #(
      .MEM_WAIT_LIMIT(4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .opcode       (opcode),
      .mem_ready    (mem_ready),
      .alu_op       (alu_op),
      .alu_src_a    (alu_src_a),
      .alu_src_b    (alu_src_b),
      .ir_write     (ir_write),
      .pc_write     (pc_write),
      .pc_write_cond(pc_write_cond),
      .pc_source    (pc_source),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .reg_write    (reg_write),
      .wb_sel       (wb_sel),
      .illegal_inst (illegal_inst)
   );

   function automatic out_t mk(input int a, input int sa, input int sb, input int irw, input int pcw,
                               input int pcc, input int pcs, input int mr, input int mw, input int rw,
                               input int wb, input int ill);
      out_t o;
      o.alu_op = 2'(a);   o.src_a = 2'(sa);  o.src_b = 2'(sb);
      o.ir_w   = 1'(irw); o.pc_w  = 1'(pcw); o.pc_c  = 1'(pcc); o.pc_s = 1'(pcs);
      o.m_r    = 1'(mr);  o.m_w   = 1'(mw);  o.r_w   = 1'(rw);
      o.wb     = 2'(wb);  o.ill   = 1'(ill);
      return o;
   endfunction

   task automatic check(input string name, input out_t got, input out_t exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%h expected=%h", name, got, exp);
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, sample 1 ns later.
   task automatic step(input logic r, input logic [6:0] op, input logic rdy, input bit do_chk,
                       input out_t exp, input string name);
      out_t got;
      @(negedge clk);
      rst = r; opcode = op; mem_ready = rdy;
      #1;
      got = {alu_op, alu_src_a, alu_src_b, ir_write, pc_write, pc_write_cond, pc_source,
             mem_read, mem_write, reg_write, wb_sel, illegal_inst};
      if (do_chk) check(name, got, exp);
   endtask

   task automatic do_reset();
      step(1'b1, OP_BAD, 1'b0, 1'b0, E_ZERO, "reset");
   endtask

   task automatic add(input logic r, input logic [6:0] op, input logic rdy, input out_t exp, input string name);
      vec_t v;
      v.rst = r; v.op = op; v.rdy = rdy; v.exp = exp; v.name = name;
      vecs.push_back(v);
   endtask

   task automatic add_alu4(input logic [6:0] op, input out_t exec, input string name);
      add(1'b0, op, 1'b1, E_FETCH_RDY, {name, "_c1"});
      add(1'b0, op, 1'b1, E_DECODE,    {name, "_c2"});
      add(1'b0, op, 1'b1, exec,        {name, "_c3"});
      add(1'b0, op, 1'b1, E_WB_ALU,    {name, "_c4"});
   endtask

   task automatic add_jump3(input logic [6:0] op, input out_t exec, input string name);
      add(1'b0, op, 1'b1, E_FETCH_RDY, {name, "_c1"});
      add(1'b0, op, 1'b1, E_DECODE,    {name, "_c2"});
      add(1'b0, op, 1'b1, exec,        {name, "_c3"});
   endtask

   initial begin
      //              aop sa sb irw pcw pcc pcs mr mw rw wb ill
      E_ZERO      = mk(0, 0, 0, 0,  0,  0,  0,  0, 0, 0, 0, 0);
      E_FETCH     = mk(0, 0, 2, 0,  0,  0,  0,  1, 0, 0, 0, 0);
      E_FETCH_RDY = mk(0, 0, 2, 1,  1,  0,  0,  1, 0, 0, 0, 0);
      E_DECODE    = mk(0, 0, 1, 0,  0,  0,  0,  0, 0, 0, 0, 0);
      E_OP_R      = mk(2, 1, 0, 0,  0,  0,  0,  0, 0, 0, 0, 0);
      E_OP_I      = mk(2, 1, 1, 0,  0,  0,  0,  0, 0, 0, 0, 0);
      E_BR        = mk(3, 1, 0, 0,  0,  1,  1,  0, 0, 0, 0, 0);
      E_JAL       = mk(0, 0, 0, 0,  1,  0,  1,  0, 0, 1, 2, 0);
      E_JALR      = mk(0, 1, 1, 0,  1,  0,  0,  0, 0, 1, 2, 0);
      E_LUI       = mk(0, 2, 1, 0,  0,  0,  0,  0, 0, 0, 0, 0);
      E_AUIPC     = mk(0, 0, 1, 0,  0,  0,  0,  0, 0, 0, 0, 0);
      E_MADDR     = mk(0, 1, 1, 0,  0,  0,  0,  0, 0, 0, 0, 0);
      E_MRD       = mk(0, 0, 0, 0,  0,  0,  0,  1, 0, 0, 0, 0);
      E_MWR       = mk(0, 0, 0, 0,  0,  0,  0,  0, 1, 0, 0, 0);
      E_WB_ALU    = mk(0, 0, 0, 0,  0,  0,  0,  0, 0, 1, 0, 0);
      E_WB_MEM    = mk(0, 0, 0, 0,  0,  0,  0,  0, 0, 1, 1, 0);
      E_TRAP      = mk(0, 0, 0, 0,  0,  0,  0,  0, 0, 0, 0, 1);

      add(1'b0, OP_OP, 1'b0, E_FETCH, "reset_fetch");
      add_alu4(OP_OP, E_OP_R, "add");
      // LOAD with mem_ready held off for three MEM_RD cycles: 8 cycles in all.
      add(1'b0, OP_LOAD, 1'b1, E_FETCH_RDY, "ld_c1");
      add(1'b0, OP_LOAD, 1'b1, E_DECODE,    "ld_c2");
      add(1'b0, OP_LOAD, 1'b1, E_MADDR,     "ld_c3");
      add(1'b0, OP_LOAD, 1'b0, E_MRD,       "ld_c4");
      add(1'b0, OP_LOAD, 1'b0, E_MRD,       "ld_c5");
      add(1'b0, OP_LOAD, 1'b0, E_MRD,       "ld_c6");
      add(1'b0, OP_LOAD, 1'b1, E_MRD,       "ld_c7");
      add(1'b0, OP_LOAD, 1'b1, E_WB_MEM,    "ld_c8");
      add_jump3(OP_BEQ, E_BR, "beq");
      add(1'b0, OP_BEQ, 1'b0, E_FETCH, "beq_c4_fetch");
      add(1'b0, OP_STORE, 1'b1, E_FETCH_RDY, "st_c1");
      add(1'b0, OP_STORE, 1'b1, E_DECODE,    "st_c2");
      add(1'b0, OP_STORE, 1'b1, E_MADDR,     "st_c3");
      add(1'b0, OP_STORE, 1'b1, E_MWR,       "st_c4");
      add_alu4(OP_IMM, E_OP_I, "addi");
      add_jump3(OP_JAL, E_JAL, "jal");
      add_jump3(OP_JALR, E_JALR, "jalr");
      add_alu4(OP_LUI, E_LUI, "lui");
      add_alu4(OP_AUIPC, E_AUIPC, "auipc");
      add_alu4(OP_32, E_OP_R, "addw");
      add_alu4(OP_IMM_32, E_OP_I, "addiw");
      // Reset lands while a store waits for mem_ready.
      add(1'b0, OP_STORE, 1'b1, E_FETCH_RDY, "rstwr_c1");
      add(1'b0, OP_STORE, 1'b1, E_DECODE,    "rstwr_c2");
      add(1'b0, OP_STORE, 1'b1, E_MADDR,     "rstwr_c3");
      add(1'b0, OP_STORE, 1'b0, E_MWR,       "rstwr_wait");
      add(1'b1, OP_STORE, 1'b0, E_ZERO,      "rstwr_reset_cycle");
      add(1'b0, OP_STORE, 1'b0, E_FETCH,     "rstwr_fetch");

      do_reset();
      do_reset();
      foreach (vecs[i]) step(vecs[i].rst, vecs[i].op, vecs[i].rdy, 1'b1, vecs[i].exp, vecs[i].name);

      // Illegal opcode: TRAP after DECODE, sticky until reset.
      do_reset();
      step(1'b0, OP_BAD, 1'b1, 1'b1, E_FETCH_RDY, "ill_fetch");
      step(1'b0, OP_BAD, 1'b1, 1'b1, E_DECODE, "ill_decode");
      for (int i = 0; i < 10; i++) step(1'b0, OP_BAD, 1'(i % 2), 1'b1, E_TRAP, "ill_trap_hold");
      do_reset();
      step(1'b0, OP_OP, 1'b0, 1'b1, E_FETCH, "ill_after_reset");

      // Fetch timeout at the limit of 4 wait cycles.
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b0, OP_OP, 1'b0, 1'b1, E_FETCH, "to_wait");
      step(1'b0, OP_OP, 1'b0, 1'b1, E_TRAP, "to_trap");

      // mem_ready on the limit cycle wins over the timeout.
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b0, OP_OP, 1'b0, 1'b1, E_FETCH, "edge_wait");
      step(1'b0, OP_OP, 1'b1, 1'b1, E_FETCH_RDY, "edge_ready");
      step(1'b0, OP_OP, 1'b1, 1'b1, E_DECODE, "edge_decode");
      step(1'b0, OP_OP, 1'b1, 1'b1, E_OP_R, "edge_exec");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter MEM_WAIT_LIMIT, default 255, the maximum number of cycles any memory state waits for mem_ready before trapping.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port opcode, input, 7 bits: the opcode field of the instruction register (inst[6:0]), valid from DECODE onward.
REQ-005 SHALL have port mem_ready, input, 1 bit: memory handshake; the current read or write completes in any cycle it is high.
REQ-006 SHALL have port alu_op, output, 2 bits, driven to ALU control: 00 ADD, 01 SUB, 10 OP (funct3/inst[30] decoded), 11 branch compare.
REQ-007 SHALL have port alu_src_a, output, 2 bits: 00 PC, 01 rs1, 10 zero.
REQ-008 SHALL have port alu_src_b, output, 2 bits: 00 rs2, 01 immediate, 10 constant 4.
REQ-009 SHALL have port ir_write, output, 1 bit: load instruction register.
REQ-010 SHALL have ports pc_write and pc_write_cond, outputs, 1 bit each: unconditional PC write, and PC write gated by branch outcome.
REQ-011 SHALL have port pc_source, output, 1 bit: 0 selects live ALU result, 1 selects registered ALU output.
REQ-012 SHALL have ports mem_read and mem_write, outputs, 1 bit each: memory request strobes.
REQ-013 SHALL have port reg_write, output, 1 bit: register file write enable.
REQ-014 SHALL have port wb_sel, output, 2 bits: 00 ALU output register, 01 memory data, 10 PC+4.
REQ-015 SHALL have port illegal_inst, output, 1 bit: sticky trap flag.

Function
REQ-016 SHALL implement states FETCH, DECODE, EXEC_OP, EXEC_BR, EXEC_JAL, EXEC_JALR, EXEC_UI, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, TRAP.
REQ-017 SHALL, in FETCH, assert mem_read, alu_src_a=00, alu_src_b=10, alu_op=00, and stay until mem_ready; on mem_ready it asserts ir_write and pc_write (pc_source=0) that same cycle and then moves to DECODE.
REQ-018 SHALL, in DECODE, compute the branch target (alu_src_a=00, alu_src_b=01, alu_op=00) and dispatch on opcode:
  - OP/OP_IMM/OP_32/OP_IMM_32 (0110011/0010011/0111011/0011011) -> EXEC_OP
  - LOAD/STORE (0000011/0100011) -> MEM_ADDR
  - BRANCH 1100011 -> EXEC_BR
  - JAL 1101111 -> EXEC_JAL
  - JALR 1100111 -> EXEC_JALR
  - LUI/AUIPC (0110111/0010111) -> EXEC_UI
  - anything else -> TRAP
REQ-019 SHALL, in EXEC_OP, drive alu_op=10 and alu_src_a=01; alu_src_b is 00 for OP/OP_32 and 01 for the immediate forms; then -> WB_ALU.
REQ-020 SHALL, in EXEC_BR, drive alu_op=11, alu_src_a=01, alu_src_b=00, pc_write_cond=1, pc_source=1; then -> FETCH.
REQ-021 SHALL, in EXEC_JAL, drive pc_write=1, pc_source=1, reg_write=1, wb_sel=10; then -> FETCH.
REQ-022 SHALL, in EXEC_JALR, drive alu_op=00, alu_src_a=01, alu_src_b=01, pc_write=1, pc_source=0, reg_write=1, wb_sel=10; then -> FETCH.
REQ-023 SHALL, in EXEC_UI, drive alu_op=00 and alu_src_b=01, with alu_src_a=10 for LUI and 00 for AUIPC; then -> WB_ALU.
REQ-024 SHALL, in MEM_ADDR, drive alu_op=00, alu_src_a=01, alu_src_b=01; then -> MEM_RD for LOAD or MEM_WR for STORE.
REQ-025 SHALL hold mem_read (MEM_RD) or mem_write (MEM_WR) high until mem_ready; on mem_ready MEM_RD -> WB_MEM and MEM_WR -> FETCH.
REQ-026 SHALL, in WB_ALU, drive reg_write=1 with wb_sel=00, and in WB_MEM drive reg_write=1 with wb_sel=01; both -> FETCH.
REQ-027 SHALL count wait cycles in FETCH, MEM_RD and MEM_WR, clearing the counter on state entry; when the count reaches MEM_WAIT_LIMIT without mem_ready, the block enters TRAP.
REQ-028 SHALL give mem_ready priority over timeout when both occur in the same cycle.
REQ-029 SHALL, in TRAP, set illegal_inst=1, deassert all write and strobe outputs, and remain in TRAP until rst.
REQ-030 SHALL drive every output not listed for a state to 0.
REQ-031 SHALL give a cycle count per instruction, assuming mem_ready is high whenever requested:
  - OP and LUI/AUIPC: 4
  - BRANCH, JAL and JALR: 3
  - STORE: 4
  - LOAD: 5

Reset
REQ-032 SHALL, on rst high at a clock edge, enter FETCH, clear the wait counter and illegal_inst, and drive all outputs to 0 except the FETCH outputs from the next cycle.
REQ-033 SHALL abandon any in-progress instruction or memory wait on reset, with no write strobe asserted in the reset cycle.

Structure
REQ-034 SHALL take opcode encodings, alu_op codes, and the mux select encodings (alu_src_a, alu_src_b, wb_sel) from the shared core definitions package, alongside the existing ALU and branch constants.
REQ-035 SHALL keep state encoding local to the module.
REQ-036 SHALL have no sub-module, except an optional wait_counter sub-module for the timeout.

Verification
REQ-037 SHALL cover: an ADD sequence with mem_ready=1 -> states FETCH, DECODE, EXEC_OP, WB_ALU; reg_write on cycle 4 with alu_op=10 in cycle 3.
REQ-038 SHALL cover: LOAD with mem_ready delayed 3 cycles in MEM_RD -> mem_read held 4 cycles, then WB_MEM with wb_sel=01; 8 cycles total.
REQ-039 SHALL cover: BEQ (opcode 1100011) -> EXEC_BR with alu_op=11 and pc_write_cond=1, back in FETCH on cycle 4.
REQ-040 SHALL cover: opcode 0000000 -> TRAP after DECODE; illegal_inst=1 held for 10 cycles; rst returns the block to FETCH with illegal_inst=0.
REQ-041 SHALL cover: mem_ready held low in FETCH with MEM_WAIT_LIMIT=4 -> TRAP after 4 wait cycles; a separate run with mem_ready rising on the limit cycle -> DECODE, no trap.
REQ-042 SHALL cover: rst asserted mid-MEM_WR -> mem_write=0 in the next cycle, state FETCH, mem_read=1.
